multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//   Iterative signed 32-bit multiply/divide unit for the CPU's MultDiv stage.
//   - Multiply: radix-2 Booth, 32 steps. Divide: restoring, 32 steps.
//   - Exactly one bit32_cla instance is the only adder; the FSM shares it across all phases.
//   - Reports a one-cycle result-ready pulse and an exception flag.
// PARAMETERS
//   WIDTH        32  operand/result width; only 32 is supported
//   CNT_W        6   iteration counter width (counts 0..31)
//   MULT_OVF_EN  1   1: flag multiply overflow; 0: data_exception never set by MULT
// PORTS
//   clock            in   1   single clock; all state updates on the rising edge
//   resetn           in   1   asynchronous, active-low reset
//   ctrl_MULT        in   1   start multiply; sampled only in IDLE or DONE
//   ctrl_DIV         in   1   start divide; sampled only in IDLE or DONE
//   data_operandA    in   32  multiplicand / dividend, latched at start
//   data_operandB    in   32  multiplier / divisor, latched at start
//   data_result      out  32  product[31:0] or quotient; held until the next ready
//   data_exception   out  1   valid with data_resultRDY; held with data_result
//   data_resultRDY   out  1   one-cycle pulse: result valid
//   busy             out  1   high from the edge after start until ready
// BEHAVIOUR
//   Reset
//   - resetn=0 forces state IDLE and clears all outputs, counter and operand registers.
//   - Reset mid-operation aborts the operation; no data_resultRDY pulse is produced.
//   Start
//   - Start is accepted on rising edge E0 when in IDLE or DONE and ctrl_MULT|ctrl_DIV=1.
//   - If both start inputs are high, MULT wins.
//   - Start inputs while busy are ignored.
//   - Operands are latched at E0; operand changes after E0 have no effect.
//   FSM states: IDLE, NEGA, NEGB, RUN, FIX, DONE
//   - MULT path: IDLE->RUN (E0); RUN x32 (E1..E32); DONE after E33.
//     data_resultRDY=1 for the cycle after E33 (latency 33).
//   - DIV path: IDLE->NEGA (E0); NEGA (E1); NEGB (E2); RUN x32 (E3..E34); FIX (E35); DONE after E36.
//     data_resultRDY=1 for the cycle after E36 (latency 36).
//   - Latency is fixed and does not depend on operand signs or values.
//   - DONE lasts one cycle, then returns to IDLE unless a new start is accepted in DONE.
//   Adder use (one add per cycle, adder overflow output unused)
//   - Subtraction is performed as A + ~B with data_cin=1.
//   - NEGA: |dividend| = 0 + ~A + 1 when A<0, else A.
//   - NEGB: |divisor|, computed the same way.
//   - Booth RUN step: bits {Q0,Q-1} select the operation on the high accumulator:
//     01 -> +M; 10 -> -M; 00 and 11 -> pass.
//     Then arithmetic shift right of the 65-bit {ACC,Q,Q-1} register.
//   - Divide RUN step: shift {R,Q} left by 1, trial R-|B|.
//     Non-negative result: keep it and set Q0=1. Negative result: restore R and set Q0=0.
//   - FIX: quotient = 0 - Q when sign(A)^sign(B), else Q.
//     The remainder is discarded.
//   Exceptions (result and flag update together with ready)
//   - MULT: exception=1 when MULT_OVF_EN=1 and product[63:32] is not all equal to product[31].
//     The result is still product[31:0].
//   - DIV by zero: result=0, exception=1. Fixed latency still applies.
//   - DIV of 0x80000000 by 0xFFFFFFFF: result=0x80000000, exception=1.
//   Outputs
//   - busy=1 in NEGA, NEGB, RUN and FIX; busy=0 in IDLE and DONE.
//   - The counter wraps 31->0 on the last RUN step, and the FSM leaves RUN on that step.
// TESTING
//   1. MULT A=7, B=-3: ready after exactly 33 edges; result 0xFFFFFFEB, exception=0; busy is high during E1..E32.
//   2. MULT A=0x00010000, B=0x00010000: result 0x00000000, exception=1.
//      Repeat with MULT_OVF_EN=0: exception=0.
//   3. DIV A=-100, B=7: ready after 36 edges; result 0xFFFFFFF2 (-14), exception=0.
//      DIV A=100, B=-7: result -14.
//   4. DIV A=5, B=0: result 0, exception=1 at latency 36.
//      DIV A=0x80000000, B=0xFFFFFFFF: result 0x80000000, exception=1.
//   5. Start handling:
//      - ctrl_MULT and ctrl_DIV high together: performs MULT.
//      - Start while busy: ignored; the first result is unchanged.
//      - New start in the DONE cycle: accepted; the next ready comes 33 edges later.
//   6. Reset: assert resetn=0 during RUN step 10. All outputs go to 0 immediately; no ready pulse follows.
//      After release, MULT 6*7 returns 42 at latency 33.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// One shared carry-lookahead adder serves every phase of the sequencer.

// 32-bit adder: 4-bit lookahead groups, group carries chained
module bit32_cla (
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        data_cin,
    output logic [31:0] data_result,
    output logic        overflow
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Per-group lookahead carries
    always_comb begin
        g    = data_operandA & data_operandB;
        p    = data_operandA ^ data_operandB;
        c    = '0;
        c[0] = data_cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        data_result = p ^ c[31:0];
        overflow    = c[32] ^ c[31];
    end
endmodule

module multdiv_sequencer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CNT_W       = 6,
    parameter bit          MULT_OVF_EN = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [2:0] {S_IDLE, S_NEGA, S_NEGB, S_RUN, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] acc;       // Booth high accumulator / division remainder
    logic [WIDTH-1:0] q;         // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] mreg;      // multiplicand / |divisor|
    logic             qm1;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf_unused;
    logic             sum_sign_c;
    logic             last_step_c;

    bit32_cla u_cla (
        .data_operandA (add_a),
        .data_operandB (add_b),
        .data_cin      (add_cin),
        .data_result   (add_sum),
        .overflow      (add_ovf_unused)
    );

    // Adder operand steering for the current phase
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_NEGA: begin
                add_b   = ~q;
                add_cin = 1'b1;
            end
            S_NEGB: begin
                add_b   = ~mreg;
                add_cin = 1'b1;
            end
            S_RUN: begin
                if (is_div) begin
                    add_a   = {acc[WIDTH-2:0], q[WIDTH-1]};
                    add_b   = ~mreg;
                    add_cin = 1'b1;
                end else begin
                    add_a = acc;
                    case ({q[0], qm1})
                        2'b01:   add_b = mreg;
                        2'b10: begin
                            add_b   = ~mreg;
                            add_cin = 1'b1;
                        end
                        default: add_b = '0;
                    endcase
                end
            end
            S_FIX: begin
                add_b   = ~q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    // True sign of the Booth partial sum, so the arithmetic shift stays exact
    // even when +/-M overflows the 32-bit accumulator
    assign sum_sign_c = add_sum[WIDTH-1]
                      ^ ((add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]));
    assign last_step_c = (cnt == CNT_W'(WIDTH-1));

    // Sequencer: state, datapath registers and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            acc            <= '0;
            q              <= '0;
            mreg           <= '0;
            qm1            <= 1'b0;
            cnt            <= '0;
            is_div         <= 1'b0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        data_resultRDY <= 1'b1;
                        if (is_div) begin
                            data_result    <= div_zero ? '0 : q;
                            data_exception <= div_zero | div_ovf;
                        end else begin
                            data_result    <= q;
                            data_exception <= MULT_OVF_EN && (acc != {WIDTH{q[WIDTH-1]}});
                        end
                    end
                    if (ctrl_MULT) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        is_div <= 1'b0;
                        acc    <= '0;
                        q      <= data_operandB;
                        mreg   <= data_operandA;
                        qm1    <= 1'b0;
                        cnt    <= '0;
                    end else if (ctrl_DIV) begin
                        state    <= S_NEGA;
                        busy     <= 1'b1;
                        is_div   <= 1'b1;
                        acc      <= '0;
                        q        <= data_operandA;
                        mreg     <= data_operandB;
                        qm1      <= 1'b0;
                        cnt      <= '0;
                        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero <= (data_operandB == '0);
                        div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_NEGA: begin
                    q     <= q[WIDTH-1] ? add_sum : q;
                    state <= S_NEGB;
                end
                S_NEGB: begin
                    mreg  <= mreg[WIDTH-1] ? add_sum : mreg;
                    state <= S_RUN;
                end
                S_RUN: begin
                    cnt <= last_step_c ? '0 : cnt + CNT_W'(1);
                    if (is_div) begin
                        if (!add_sum[WIDTH-1]) begin
                            acc <= add_sum;
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {acc[WIDTH-2:0], q[WIDTH-1]};
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {sum_sign_c, add_sum[WIDTH-1:1]};
                        q   <= {add_sum[0], q[WIDTH-1:1]};
                        qm1 <= q[0];
                    end
                    if (last_step_c) begin
                        state <= is_div ? S_FIX : S_DONE;
                        busy  <= is_div;
                    end
                end
                S_FIX: begin
                    q     <= neg_q ? add_sum : q;
                    state <= S_DONE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed table, random ops against an
// arithmetic reference model, and hand sequences for start/reset corners.
module tb_multdiv_sequencer;
    logic        clock = 1'b0;
    logic        resetn;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] r0, r1;
    logic        e0, e1, rdy0, rdy1, busy0, busy1;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          e;
        bit          e1;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    multdiv_sequencer dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (r0),
        .data_exception (e0),
        .data_resultRDY (rdy0),
        .busy           (busy0)
    );

    multdiv_sequencer #(.MULT_OVF_EN(1'b0)) dut_noovf (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (r1),
        .data_exception (e1),
        .data_resultRDY (rdy1),
        .busy           (busy1)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: plain signed arithmetic
    function automatic void ref_model(input bit m, input bit ovf_en, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r, output bit e);
        longint pa;
        if (m) begin
            pa = longint'($signed(a)) * longint'($signed(b));
            r  = pa[31:0];
            e  = ovf_en && (pa != longint'($signed(pa[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'($signed(a) / $signed(b));
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return 32'($urandom);
        endcase
    endfunction

    // Count negedges (k) after the start edge until ready; track busy and twin sync
    task automatic wait_ready(input int k0, input int exp_lat, input int inject_k,
                              output int lat, output bit seq_ok);
        lat    = -1;
        seq_ok = 1'b1;
        for (int k = k0; k <= 80; k++) begin
            if (rdy1 !== rdy0 || busy1 !== busy0) seq_ok = 1'b0;
            if (rdy0 === 1'b1) begin
                lat = k;
                break;
            end
            if (busy0 !== 1'(k < exp_lat - 1)) seq_ok = 1'b0;
            if (k == inject_k) begin
                ctrl_MULT = 1'b1;
                ctrl_DIV  = 1'b1;
                op_a      = 32'd1000;
                op_b      = 32'd3;
            end else if (k == inject_k + 1) begin
                ctrl_MULT = 1'b0;
                ctrl_DIV  = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input bit exp_e,
                          input bit exp_e1, input int exp_lat, input int inject_k);
        int lat;
        bit seq_ok;
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        op_a      = a;
        op_b      = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        wait_ready(0, exp_lat, inject_k, lat, seq_ok);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(r0), 64'(exp_r));
        check({name, " exception"}, 64'(e0), 64'(exp_e));
        check({name, " result noovf"}, 64'(r1), 64'(exp_r));
        check({name, " exception noovf"}, 64'(e1), 64'(exp_e1));
        check({name, " busy/sync"}, 64'(seq_ok), 64'd1);
        @(negedge clock);
        check({name, " pulse/hold"}, 64'({rdy0, r0}), 64'({1'b0, exp_r}));
    endtask

    initial begin
        int          lat;
        int          k_done;
        int          n_rdy;
        bit          seq_ok;
        bit          m;
        logic [31:0] a, b, er, er1;
        bit          ee, ee1;

        vecs.push_back('{"mul 7*-3",        1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 33});
        vecs.push_back('{"mul 2^16*2^16",   1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 0, 33});
        vecs.push_back('{"mul min*min",     1, 0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1, 0, 33});
        vecs.push_back('{"mul min*1",       1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 0, 33});
        vecs.push_back('{"mul max*2",       1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1, 0, 33});
        vecs.push_back('{"both high 6*7",   1, 1, 32'd6,          32'd7,         32'd42,        0, 0, 33});
        vecs.push_back('{"div -100/7",      0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0, 0, 36});
        vecs.push_back('{"div 100/-7",      0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 0, 36});
        vecs.push_back('{"div 5/0",         0, 1, 32'd5,          32'd0,         32'd0,         1, 1, 36});
        vecs.push_back('{"div min/-1",      0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 36});
        vecs.push_back('{"div min/1",       0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 0, 36});
        vecs.push_back('{"div min/min",     0, 1, 32'h8000_0000,  32'h8000_0000, 32'd1,         0, 0, 36});
        vecs.push_back('{"div 7/-100",      0, 1, 32'd7,          32'hFFFF_FF9C, 32'd0,         0, 0, 36});

        resetn    = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clock);
        check("reset state", 64'({r0, e0, rdy0, busy0}), 64'd0);
        check("reset state noovf", 64'({r1, e1, rdy1, busy1}), 64'd0);
        resetn = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].e, vecs[i].e1, vecs[i].lat, -1);

        for (int i = 0; i < 50; i++) begin
            m = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            ref_model(m, 1'b1, a, b, er, ee);
            ref_model(m, 1'b0, a, b, er1, ee1);
            run_op($sformatf("rand%0d", i), m, !m, a, b, er, ee, ee1, m ? 33 : 36, -1);
        end

        // Start inputs pulsed mid-operation must be ignored
        run_op("busy ignore", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33, 10);
        n_rdy = 0;
        repeat (45) begin
            @(negedge clock);
            if (rdy0 === 1'b1) n_rdy++;
        end
        check("busy ignore extra ready", 64'(n_rdy), 64'd0);
        check("busy ignore result held", 64'(r0), 64'hFFFF_FFEB);

        // New start in the DONE cycle (busy just dropped, ready not yet out)
        @(negedge clock);
        ctrl_MULT = 1'b1;
        op_a      = 32'd3;
        op_b      = 32'd5;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        k_done    = -1;
        for (int k = 0; k <= 60; k++) begin
            if (busy0 === 1'b0) begin
                k_done = k;
                break;
            end
            @(negedge clock);
        end
        check("done cycle position", 64'(k_done), 64'd32);
        check("done cycle ready low", 64'(rdy0), 64'd0);
        ctrl_MULT = 1'b1;
        op_a      = 32'd6;
        op_b      = 32'd7;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        check("done cycle first result", 64'({rdy0, r0}), 64'({1'b1, 32'd15}));
        @(negedge clock);
        wait_ready(1, 33, -1, lat, seq_ok);
        check("done restart latency", 64'(lat), 64'd33);
        check("done restart result", 64'(r0), 64'd42);
        check("done restart busy/sync", 64'(seq_ok), 64'd1);

        // Reset in the middle of RUN: outputs clear at once, no ready follows
        @(negedge clock);
        ctrl_MULT = 1'b1;
        op_a      = 32'd123456;
        op_b      = 32'd789;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (10) @(negedge clock);
        check("busy before reset", 64'(busy0), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async reset outputs", 64'({r0, e0, rdy0, busy0}), 64'd0);
        check("async reset outputs noovf", 64'({r1, e1, rdy1, busy1}), 64'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        n_rdy  = 0;
        repeat (50) begin
            @(negedge clock);
            if (rdy0 === 1'b1 || busy0 === 1'b1) n_rdy++;
        end
        check("no activity after reset", 64'(n_rdy), 64'd0);
        run_op("post reset 6*7", 1'b1, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 33, -1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
